// File: rtl/idecode_stage_if.sv
// Fetch/execute/writeback bus seen by the decode stage.
// The slave modport is the decode stage; the master modport is its surroundings.
interface idecode_stage_if;
    logic        stall_v_o;
    logic        bubble_v_o;
    logic [31:0] pc_i;
    logic        inst_v_i;
    logic [31:0] inst_i;
    logic        flush_i;
    logic        stall_v_i;
    logic        ex_load_v_i;
    logic [4:0]  ex_rd_i;
    logic        wb_v_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [6:0]  opcode_o;
    logic [4:0]  rd_o;
    logic [2:0]  funct3_o;
    logic        funct7b5_o;
    logic [4:0]  rs1_o;
    logic [4:0]  rs2_o;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic [31:0] imm_o;
    logic        illegal_o;

    modport slave (
        input  pc_i, inst_v_i, inst_i, flush_i, stall_v_i, ex_load_v_i, ex_rd_i,
               wb_v_i, wb_rd_i, wb_data_i,
        output stall_v_o, bubble_v_o, valid_o, pc_o, opcode_o, rd_o, funct3_o,
               funct7b5_o, rs1_o, rs2_o, rs1_data_o, rs2_data_o, imm_o, illegal_o
    );

    modport master (
        output pc_i, inst_v_i, inst_i, flush_i, stall_v_i, ex_load_v_i, ex_rd_i,
               wb_v_i, wb_rd_i, wb_data_i,
        input  stall_v_o, bubble_v_o, valid_o, pc_o, opcode_o, rd_o, funct3_o,
               funct7b5_o, rs1_o, rs2_o, rs1_data_o, rs2_data_o, imm_o, illegal_o
    );
endinterface

// File: rtl/idecode_stage.sv
// RV32I decode stage: IF/ID register, 32x32 register file, field/immediate decode, load-use hazard.
// Optional macro RVGA_WB_BYPASS_EN forwards same-cycle writeback data onto the register reads.
module idecode_stage #(
    parameter int          NREGS    = 32,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input logic          clk_i,
    input logic          rst_i,
    idecode_stage_if.slave bus
);
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        v_q;
    logic [31:0] regs [NREGS];

    logic [6:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        legal;
    logic        hazard;
    logic [31:0] imm;

    assign opcode = inst_q[6:0];
    assign rs1    = inst_q[19:15];
    assign rs2    = inst_q[24:20];

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        legal    = 1'b0;
        imm      = 32'h0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                legal = 1'b1;
                imm   = {inst_q[31:12], 12'b0};
            end
            OPC_JAL: begin
                legal = 1'b1;
                imm   = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                legal    = 1'b1;
                uses_rs1 = 1'b1;
                imm      = {{20{inst_q[31]}}, inst_q[31:20]};
            end
            OPC_BRANCH: begin
                legal    = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
            end
            OPC_STORE: begin
                legal    = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                imm      = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
            end
            OPC_OP: begin
                legal    = 1'b1;
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_MISC, OPC_SYSTEM: legal = 1'b1;
            default: ;
        endcase
    end

    // Only sources the opcode really reads can create a load-use dependency.
    assign hazard = v_q & bus.ex_load_v_i & (bus.ex_rd_i != 5'd0) &
                    ((uses_rs1 & (bus.ex_rd_i == rs1)) | (uses_rs2 & (bus.ex_rd_i == rs2)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q   <= 32'h0;
            inst_q <= NOP_INST;
            v_q    <= 1'b0;
        end else if (bus.flush_i) begin
            inst_q <= NOP_INST;
            v_q    <= 1'b0;
        end else if (!(bus.stall_v_i || hazard)) begin
            pc_q   <= bus.pc_i;
            inst_q <= bus.inst_i;
            v_q    <= bus.inst_v_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 32'h0;
        end else if (bus.wb_v_i && (bus.wb_rd_i != 5'd0)) begin
            regs[bus.wb_rd_i] <= bus.wb_data_i;
        end
    end

`ifdef RVGA_WB_BYPASS_EN
    assign bus.rs1_data_o = (rs1 == 5'd0) ? 32'h0 :
                            (bus.wb_v_i && (bus.wb_rd_i == rs1)) ? bus.wb_data_i : regs[rs1];
    assign bus.rs2_data_o = (rs2 == 5'd0) ? 32'h0 :
                            (bus.wb_v_i && (bus.wb_rd_i == rs2)) ? bus.wb_data_i : regs[rs2];
`else
    assign bus.rs1_data_o = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
    assign bus.rs2_data_o = (rs2 == 5'd0) ? 32'h0 : regs[rs2];
`endif

    // A squashed instruction never stalls fetch; a downstream stall always does.
    assign bus.stall_v_o  = (hazard & ~bus.flush_i) | bus.stall_v_i;
    assign bus.bubble_v_o = bus.flush_i;
    assign bus.valid_o    = v_q & ~hazard & ~bus.flush_i & ~rst_i;
    assign bus.pc_o       = pc_q;
    assign bus.opcode_o   = opcode;
    assign bus.rd_o       = inst_q[11:7];
    assign bus.funct3_o   = inst_q[14:12];
    assign bus.funct7b5_o = inst_q[30];
    assign bus.rs1_o      = rs1;
    assign bus.rs2_o      = rs2;
    assign bus.imm_o      = imm;
    assign bus.illegal_o  = v_q & ~legal;
endmodule

// File: tb/tb_idecode_stage.sv
// Directed bench for idecode_stage: decode, regfile, load-use hazard, flush, reset.
// Expectations for the same-cycle writeback read follow RVGA_WB_BYPASS_EN.
module tb_idecode_stage;
    logic clk_i = 1'b0;
    logic rst_i;
    int   compared   = 0;
    int   mismatched = 0;

    idecode_stage_if bus ();

    idecode_stage dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst, input logic v);
        bus.pc_i     = pc;
        bus.inst_i   = inst;
        bus.inst_v_i = v;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    initial begin
        logic [31:0] x7_same_cycle;
        rst_i           = 1'b1;
        bus.flush_i     = 1'b0;
        bus.stall_v_i   = 1'b0;
        bus.ex_load_v_i = 1'b0;
        bus.ex_rd_i     = 5'd0;
        bus.wb_v_i      = 1'b0;
        bus.wb_rd_i     = 5'd0;
        bus.wb_data_i   = 32'h0;
        applyStimulus(32'h0, 32'h0, 1'b0);

        // Reset state
        tick();
        tick();
        checkOutput("rst_valid", {31'b0, bus.valid_o}, 32'h0);
        checkOutput("rst_pc", bus.pc_o, 32'h0);
        checkOutput("rst_opcode", {25'b0, bus.opcode_o}, 32'h13);
        checkOutput("rst_bubble", {31'b0, bus.bubble_v_o}, 32'h0);
        checkOutput("rst_stall", {31'b0, bus.stall_v_o}, 32'h0);
        rst_i = 1'b0;

        // addi x1,x0,5
        applyStimulus(32'h100, 32'h00500093, 1'b1);
        tick();
        checkOutput("addi_valid", {31'b0, bus.valid_o}, 32'h1);
        checkOutput("addi_pc", bus.pc_o, 32'h100);
        checkOutput("addi_rd", {27'b0, bus.rd_o}, 32'h1);
        checkOutput("addi_imm", bus.imm_o, 32'h5);
        checkOutput("addi_rs1data", bus.rs1_data_o, 32'h0);

        // x2 <= DEADBEEF in the same edge that loads sw x2,-4(x1)
        bus.wb_v_i    = 1'b1;
        bus.wb_rd_i   = 5'd2;
        bus.wb_data_i = 32'hDEADBEEF;
        applyStimulus(32'h104, 32'hFE20AE23, 1'b1);
        tick();
        bus.wb_v_i = 1'b0;
        settle();
        checkOutput("sw_imm", bus.imm_o, 32'hFFFFFFFC);
        checkOutput("sw_rs2data", bus.rs2_data_o, 32'hDEADBEEF);
        checkOutput("sw_illegal", {31'b0, bus.illegal_o}, 32'h0);
        checkOutput("sw_rs1", {27'b0, bus.rs1_o}, 32'h1);
        checkOutput("sw_rs2", {27'b0, bus.rs2_o}, 32'h2);

        // add x4,x3,x5 against a load to x3
        applyStimulus(32'h108, 32'h00518233, 1'b1);
        tick();
        bus.ex_load_v_i = 1'b1;
        bus.ex_rd_i     = 5'd3;
        applyStimulus(32'h10C, 32'h00000013, 1'b1);
        settle();
        checkOutput("haz_stall", {31'b0, bus.stall_v_o}, 32'h1);
        checkOutput("haz_valid", {31'b0, bus.valid_o}, 32'h0);
        checkOutput("haz_bubble", {31'b0, bus.bubble_v_o}, 32'h0);
        tick();
        checkOutput("haz_hold_pc", bus.pc_o, 32'h108);
        bus.ex_load_v_i = 1'b0;
        settle();
        checkOutput("haz_release_valid", {31'b0, bus.valid_o}, 32'h1);
        checkOutput("haz_release_pc", bus.pc_o, 32'h108);
        checkOutput("haz_release_stall", {31'b0, bus.stall_v_o}, 32'h0);

        // lui x3 with rs1 field == 3 never hazards
        applyStimulus(32'h10C, 32'h000181B7, 1'b1);
        tick();
        bus.ex_load_v_i = 1'b1;
        bus.ex_rd_i     = 5'd3;
        settle();
        checkOutput("lui_stall", {31'b0, bus.stall_v_o}, 32'h0);
        checkOutput("lui_valid", {31'b0, bus.valid_o}, 32'h1);
        checkOutput("lui_imm", bus.imm_o, 32'h00018000);

        // Hazard and flush together
        applyStimulus(32'h110, 32'h00518233, 1'b1);
        tick();
        checkOutput("pre_flush_stall", {31'b0, bus.stall_v_o}, 32'h1);
        bus.flush_i = 1'b1;
        settle();
        checkOutput("flush_stall", {31'b0, bus.stall_v_o}, 32'h0);
        checkOutput("flush_bubble", {31'b0, bus.bubble_v_o}, 32'h1);
        checkOutput("flush_valid", {31'b0, bus.valid_o}, 32'h0);
        tick();
        bus.flush_i     = 1'b0;
        bus.ex_load_v_i = 1'b0;
        settle();
        checkOutput("post_flush_valid", {31'b0, bus.valid_o}, 32'h0);
        checkOutput("post_flush_opcode", {25'b0, bus.opcode_o}, 32'h13);

        // Writes to x0 are dropped
        bus.wb_v_i    = 1'b1;
        bus.wb_rd_i   = 5'd0;
        bus.wb_data_i = 32'h1234;
        applyStimulus(32'h114, 32'h00500093, 1'b1);
        tick();
        checkOutput("x0_read", bus.rs1_data_o, 32'h0);

        // x7 <= AAAA5555, then same-cycle write of 1234 while addi x8,x7,1 reads it
        bus.wb_rd_i   = 5'd7;
        bus.wb_data_i = 32'hAAAA5555;
        applyStimulus(32'h118, 32'h00138413, 1'b1);
        tick();
        bus.wb_data_i = 32'h1234;
        settle();
`ifdef RVGA_WB_BYPASS_EN
        x7_same_cycle = 32'h1234;
`else
        x7_same_cycle = 32'hAAAA5555;
`endif
        checkOutput("x7_same_cycle", bus.rs1_data_o, x7_same_cycle);
        checkOutput("x7_imm", bus.imm_o, 32'h1);
        tick();
        bus.wb_v_i = 1'b0;
        settle();
        checkOutput("x7_after_write", bus.rs1_data_o, 32'h1234);

        // Illegal opcode
        applyStimulus(32'h11C, 32'h0000007F, 1'b1);
        tick();
        checkOutput("ill_flag", {31'b0, bus.illegal_o}, 32'h1);
        checkOutput("ill_imm", bus.imm_o, 32'h0);
        checkOutput("ill_valid", {31'b0, bus.valid_o}, 32'h1);

        // Reset mid-stream
        rst_i = 1'b1;
        settle();
        checkOutput("midrst_valid_now", {31'b0, bus.valid_o}, 32'h0);
        tick();
        rst_i = 1'b0;
        applyStimulus(32'h200, 32'h002380B3, 1'b1);
        settle();
        checkOutput("midrst_valid", {31'b0, bus.valid_o}, 32'h0);
        checkOutput("midrst_pc", bus.pc_o, 32'h0);
        tick();
        checkOutput("midrst_x7", bus.rs1_data_o, 32'h0);
        checkOutput("midrst_x2", bus.rs2_data_o, 32'h0);
        checkOutput("midrst_new_pc", bus.pc_o, 32'h200);

        // Downstream stall freezes decode
        bus.stall_v_i = 1'b1;
        applyStimulus(32'h204, 32'h00500093, 1'b1);
        settle();
        checkOutput("dstall_stall", {31'b0, bus.stall_v_o}, 32'h1);
        tick();
        checkOutput("dstall_hold_pc", bus.pc_o, 32'h200);
        bus.stall_v_i = 1'b0;
        tick();
        checkOutput("dstall_release_pc", bus.pc_o, 32'h204);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/idecode_stage.md
Name: idecode_stage

Overview:
- Decode stage directly downstream of instruction fetch.
- Holds the IF/ID pipeline register and an internal 32x32 integer register file.
- Decodes RV32I fields and immediates, reads rs1/rs2, and presents a decoded bundle to execute.
- Detects load-use hazards and drives stall/bubble requests back to fetch.

Parameters:
- NREGS, 32, number of architectural registers; x0 is hardwired to zero.
- NOP_INST, 32'h00000013, instruction loaded into the IF/ID register on reset and flush (addi x0,x0,0).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- pc_i  in  32  PC of the fetched instruction
- inst_v_i  in  1  fetched instruction valid
- inst_i  in  32  fetched instruction word
- stall_v_o  out  1  hold fetch PC; asserted on a load-use hazard or downstream stall
- bubble_v_o  out  1  fetch output is to be discarded; asserted on flush
- flush_i  in  1  branch taken in execute; squash the instruction in decode
- stall_v_i  in  1  execute cannot accept; freeze decode
- ex_load_v_i  in  1  instruction in execute is a load
- ex_rd_i  in  5  destination register of the instruction in execute
- wb_v_i  in  1  writeback enable
- wb_rd_i  in  5  writeback destination register
- wb_data_i  in  32  writeback data
- valid_o  out  1  decoded bundle valid
- pc_o  out  32  PC of the decoded instruction
- opcode_o  out  7  inst[6:0]
- rd_o  out  5  inst[11:7]
- funct3_o  out  3  inst[14:12]
- funct7b5_o  out  1  inst[30]
- rs1_o  out  5  inst[19:15]
- rs2_o  out  5  inst[24:20]
- rs1_data_o  out  32  register file read, port 1
- rs2_data_o  out  32  register file read, port 2
- imm_o  out  32  sign-extended immediate
- illegal_o  out  1  opcode is not RV32I

Behaviour:
- IF/ID register (pc_q, inst_q, v_q):
  - Reset: pc_q=0, inst_q=NOP_INST, v_q=0.
  - Update priority on each posedge:
    1. rst_i.
    2. flush_i: inst_q=NOP_INST, v_q=0.
    3. stall_v_i or hazard: hold.
    4. Otherwise load pc_i, inst_i, inst_v_i.
- Latency: an instruction presented on inst_i in cycle N appears decoded on the outputs in cycle N+1. All decoded outputs are combinational from the IF/ID register and the register file.
- Hazard: asserted when v_q, ex_load_v_i, ex_rd_i!=0, and ex_rd_i matches a source the opcode actually uses:
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
  - LUI, AUIPC, JAL use no sources and never hazard.
- Output and handshake rules:
  - valid_o = v_q & ~hazard & ~flush_i.
  - stall_v_o = hazard | stall_v_i.
  - bubble_v_o = flush_i.
  - Flush wins over hazard: no stall is asserted for a squashed instruction.
- Immediate formats, by opcode:
  - I: OP-IMM, LOAD, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - All immediates sign-extend from inst[31]. B and J immediates have bit0 = 0. U immediate = {inst[31:12], 12'b0}.
  - Any other opcode: imm_o=0.
- illegal_o = v_q & opcode not in {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM}. It is not masked by hazard.
- Register file:
  - Reset clears all entries to 0.
  - Write at posedge when wb_v_i and wb_rd_i!=0; writes to x0 are ignored.
  - Reads of x0 always return 0.
  - Writeback is independent of stall and flush.
- Reset mid-operation: all state returns to reset values the next cycle; valid_o=0 while rst_i is high.

Optional Feature:
- Macro: RVGA_WB_BYPASS_EN.
- Defined: if wb_v_i, wb_rd_i!=0 and wb_rd_i==rs1_o (resp. rs2_o), the read returns wb_data_i in the same cycle (write-before-read).
- Undefined: reads return the stored value; the new value is visible from the cycle after the write.

Test Plan:
- Reset, then present pc_i=0x100, inst_i=0x00500093 (addi x1,x0,5) -> next cycle: valid_o=1, pc_o=0x100, rd_o=1, imm_o=5, rs1_data_o=0.
- Pre-write x2=0xDEADBEEF via wb; decode sw x2,-4(x1) (0xFE20AE23) -> imm_o=0xFFFFFFFC, rs2_data_o=0xDEADBEEF, illegal_o=0.
- ex_load_v_i=1, ex_rd_i=3; decode add x4,x3,x5 -> stall_v_o=1, valid_o=0, IF/ID held.
  - Drop ex_load_v_i -> valid_o=1 with the same pc_o.
  - Repeat with lui x3 in decode -> no stall.
- Hazard and flush_i asserted together -> stall_v_o=0, bubble_v_o=1, valid_o=0; next cycle v_q=0.
- wb_v_i=1, wb_rd_i=0, wb_data_i=0x1234 -> a read of x0 returns 0.
  - wb to x7 with decode of rs1=7 in the same cycle -> 0x1234 same cycle with RVGA_WB_BYPASS_EN defined; old value without it.
- inst_i=0x0000007F -> illegal_o=1, imm_o=0. Assert rst_i mid-stream -> valid_o=0 the next cycle and all registers read 0.
